// File: rtl/round_sequencer_if.sv
// Bundle of play-controller signals between the board-side driver and round_sequencer.
// The sequencer takes the slave view; whoever drives the buttons takes the master view.
interface round_sequencer_if;
    logic       start_i;
    logic [3:0] buttons_i;
    logic [1:0] mode_o;
    logic [1:0] selected_o;
    logic       round_reset_o;
    logic       round_active_o;
    logic       timeout_o;

    modport master (
        output start_i,
        output buttons_i,
        input  mode_o,
        input  selected_o,
        input  round_reset_o,
        input  round_active_o,
        input  timeout_o
    );

    modport slave (
        input  start_i,
        input  buttons_i,
        output mode_o,
        output selected_o,
        output round_reset_o,
        output round_active_o,
        output timeout_o
    );
endinterface

// File: rtl/round_sequencer.sv
// Play controller: debounces four buttons, walks IDLE/SELECT/CLEAR/RUN, and times
// the round-reset pulse and the round itself.
module round_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 8,
    parameter int ROUND_CYCLES    = 1000
) (
    input  logic             clock_i,
    input  logic             reset_i,
    round_sequencer_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int RW = $clog2(ROUND_CYCLES);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] ROUND_LAST = RW'(ROUND_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SELECT = 2'b01,
        CLEAR  = 2'b10,
        RUN    = 2'b11
    } state_t;

    logic [3:0]    r_syncA;
    logic [3:0]    r_syncB;
    logic [3:0]    r_deb;
    logic [3:0]    r_debDly;
    logic [3:0]    r_press;
    logic [DW-1:0] r_debCount [4];

    state_t        r_state;
    state_t        w_nextState;
    logic [HW-1:0] r_holdCount;
    logic [RW-1:0] r_roundCount;
    logic [1:0]    r_selected;
    logic          r_roundReset;
    logic          r_roundActive;
    logic          r_timeout;

    logic          w_anyPress;
    logic [1:0]    w_winner;
    logic          w_timeout;

    // A level is accepted only after it has differed from the debounced value for
    // DEBOUNCE_CYCLES consecutive synchronized samples; any return resets the count.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_syncA  <= '0;
            r_syncB  <= '0;
            r_deb    <= '0;
            r_debDly <= '0;
            r_press  <= '0;
            for (int k = 0; k < 4; k++) begin
                r_debCount[k] <= '0;
            end
        end else begin
            r_syncA  <= bus.buttons_i;
            r_syncB  <= r_syncA;
            r_debDly <= r_deb;
            r_press  <= r_deb & ~r_debDly;
            for (int k = 0; k < 4; k++) begin
                if (r_syncB[k] == r_deb[k]) begin
                    r_debCount[k] <= '0;
                end else if (r_debCount[k] == DEB_LAST) begin
                    r_deb[k]      <= r_syncB[k];
                    r_debCount[k] <= '0;
                end else begin
                    r_debCount[k] <= r_debCount[k] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        w_anyPress = |r_press;
        w_winner   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (r_press[k]) begin
                w_winner = 2'(k);
            end
        end
    end

    // Abort is tested before terminal count so a simultaneous start wins.
    always_comb begin
        w_nextState = r_state;
        w_timeout   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start_i) w_nextState = SELECT;
            end
            SELECT: begin
                if (w_anyPress) w_nextState = CLEAR;
            end
            CLEAR: begin
                if (r_holdCount == HOLD_LAST) w_nextState = RUN;
            end
            RUN: begin
                if (bus.start_i) begin
                    w_nextState = IDLE;
                end else if (r_roundCount == ROUND_LAST) begin
                    w_nextState = IDLE;
                    w_timeout   = 1'b1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with mode_o.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state       <= IDLE;
            r_holdCount   <= '0;
            r_roundCount  <= '0;
            r_selected    <= '0;
            r_roundReset  <= 1'b0;
            r_roundActive <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_roundReset  <= (w_nextState == CLEAR);
            r_roundActive <= (w_nextState == RUN);
            r_timeout     <= w_timeout;
            if (r_state == CLEAR && w_nextState == CLEAR) begin
                r_holdCount <= r_holdCount + HW'(1);
            end else begin
                r_holdCount <= '0;
            end
            if (r_state == RUN && w_nextState == RUN) begin
                r_roundCount <= r_roundCount + RW'(1);
            end else begin
                r_roundCount <= '0;
            end
            if (r_state == SELECT && w_anyPress) begin
                r_selected <= w_winner;
            end
        end
    end

    assign bus.mode_o         = r_state;
    assign bus.selected_o     = r_selected;
    assign bus.round_reset_o  = r_roundReset;
    assign bus.round_active_o = r_roundActive;
    assign bus.timeout_o      = r_timeout;
endmodule
